// File: rtl/obstacle_scheduler_if.sv
// obstacle_scheduler_if: frame/start/hit inputs and obstacle/score outputs of the scheduler
interface obstacle_scheduler_if #(parameter int CORDW = 11);
  logic frame, start, hit;
  logic signed [CORDW-1:0] obs0_x, obs1_x;
  logic obs0_act, obs1_act;
  logic [3:0] speed;
  logic [15:0] score;
  logic [1:0] state;
  modport master (output frame, start, hit,
                  input obs0_x, obs1_x, obs0_act, obs1_act, speed, score, state);
  modport slave (input frame, start, hit,
                 output obs0_x, obs1_x, obs0_act, obs1_act, speed, score, state);
endinterface

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: two-slot obstacle pool, score/speed ramp and IDLE/RUN/OVER game sequencing
module obstacle_scheduler #(
  parameter int H_RES = 784,
  parameter int CORDW = 11,
  parameter int SPR_DRAWW = 32,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX = 6,
  parameter int SPEEDUP_PTS = 4,
  parameter int GAP_MIN = 100,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic clk,
  input logic rst,
  obstacle_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2;
  localparam logic signed [CORDW-1:0] X_SPAWN = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] X_RET = CORDW'(-SPR_DRAWW);
  logic [1:0] st;
  logic signed [CORDW-1:0] x0, x1, m0, m1;
  logic a0, a1, hl, r0, r1, spawn, s0, s1, up, clr;
  logic [3:0] spd;
  logic [15:0] sc;
  logic [16:0] sc_sum;
  logic [7:0] lfsr, rc, rc_sum;
  logic [8:0] gap;
  logic [1:0] nret;
  assign m0 = x0 - $signed({{(CORDW-4){1'b0}}, spd});
  assign m1 = x1 - $signed({{(CORDW-4){1'b0}}, spd});
  assign r0 = a0 && m0 <= X_RET;
  assign r1 = a1 && m1 <= X_RET;
  // free-ness is judged on pre-frame occupancy, so a slot retiring now cannot respawn until next frame
  assign spawn = gap == 9'd0 && !(a0 && a1);
  assign s0 = spawn && !a0;
  assign s1 = spawn && a0 && !a1;
  assign nret = {1'b0, r0} + {1'b0, r1};
  assign sc_sum = {1'b0, sc} + {15'd0, nret};
  assign rc_sum = rc + {6'd0, nret};
  assign up = rc_sum >= 8'(SPEEDUP_PTS);
  assign clr = st == IDLE || st == 2'd3 || (st == OVER && bus.start);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      x0 <= X_SPAWN;
      x1 <= X_SPAWN;
      a0 <= 1'b0;
      a1 <= 1'b0;
      spd <= 4'(SPEED_INIT);
      sc <= 16'd0;
      lfsr <= LFSR_SEED;
      gap <= 9'd0;
      rc <= 8'd0;
      hl <= 1'b0;
    end else if (clr) begin
      st <= (st == IDLE && bus.start) ? RUN : IDLE;
      x0 <= X_SPAWN;
      x1 <= X_SPAWN;
      a0 <= 1'b0;
      a1 <= 1'b0;
      spd <= 4'(SPEED_INIT);
      sc <= 16'd0;
      lfsr <= LFSR_SEED;
      gap <= 9'd0;
      rc <= 8'd0;
      hl <= 1'b0;
    end else if (st == RUN) begin
      if (bus.frame && (hl || bus.hit)) begin
        st <= OVER;
        hl <= 1'b0;
      end else if (bus.frame) begin
        x0 <= (s0 || r0 || !a0) ? X_SPAWN : m0;
        x1 <= (s1 || r1 || !a1) ? X_SPAWN : m1;
        a0 <= s0 || (a0 && !r0);
        a1 <= s1 || (a1 && !r1);
        sc <= sc_sum[16] ? 16'hFFFF : sc_sum[15:0];
        rc <= up ? 8'd0 : rc_sum;
        spd <= (up && spd < 4'(SPEED_MAX)) ? spd + 4'd1 : spd;
        gap <= gap != 9'd0 ? gap - 9'd1 : spawn ? 9'(GAP_MIN) + {3'd0, lfsr[5:0]} : 9'd0;
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end else if (bus.hit) begin
        hl <= 1'b1;
      end
    end
  end
  assign bus.obs0_x = x0;
  assign bus.obs1_x = x1;
  assign bus.obs0_act = a0;
  assign bus.obs1_act = a1;
  assign bus.speed = spd;
  assign bus.score = sc;
  assign bus.state = st;
endmodule
